// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO fabric: RV32 load/store funct3 codes,
// FSM state encoding and the access legality check used at decode.
package mmio_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Reserved funct3 codes or an address not aligned to the access size.
    function automatic logic access_illegal(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic f3_bad;
        logic misaligned;
        if (we) begin
            f3_bad = funct3[2] || (funct3[1:0] == 2'b11);
        end else begin
            f3_bad = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
        end
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return f3_bad || misaligned;
    endfunction

endpackage

// File: rtl/mmio_if.sv
// Bus bundles for the fabric: the core-facing request/response port and the
// device-facing one-hot request port with flattened read data.
interface mmio_cpu_if;
    import mmio_pkg::*;

    logic                 cpu_req;
    logic                 cpu_we;
    logic [31:0]          cpu_addr;
    logic [31:0]          cpu_wdata;
    logic [2:0]           cpu_funct3;
    logic                 cpu_stall;
    logic                 cpu_done;
    logic [31:0]          cpu_rdata;
    logic                 cpu_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
        input  cpu_stall, cpu_done, cpu_rdata, cpu_err, err_cnt
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
        output cpu_stall, cpu_done, cpu_rdata, cpu_err, err_cnt
    );
endinterface

interface mmio_dev_if #(
    parameter int NUM_DEV = 4,
    parameter int OFS_W   = 8
);
    logic [NUM_DEV-1:0]    dev_req;
    logic                  dev_we;
    logic [OFS_W-1:0]      dev_addr;
    logic [31:0]           dev_wdata;
    logic [3:0]            dev_be;
    logic [NUM_DEV-1:0]    dev_ready;
    logic [NUM_DEV*32-1:0] dev_rdata;

    modport master (
        output dev_req, dev_we, dev_addr, dev_wdata, dev_be,
        input  dev_ready, dev_rdata
    );

    modport slave (
        input  dev_req, dev_we, dev_addr, dev_wdata, dev_be,
        output dev_ready, dev_rdata
    );
endinterface

// File: rtl/mmio_lane.sv
// RV32 byte-lane handling: store byte enables and lane replication, and load
// byte/halfword extraction with sign or zero extension.
module mmio_lane
    import mmio_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                wdata_rep = {4{wdata[7:0]}};
                if (we) begin
                    be = 4'b0001 << addr_lo;
                end
            end
            2'b01: begin
                wdata_rep = {2{wdata[15:0]}};
                if (we) begin
                    be = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel = rdata[7:0];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: ;
        endcase
    end

    always_comb begin
        rdata_ext = rdata;
        case (funct3)
            F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_ext = {24'b0, byte_sel};
            F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_ext = {16'b0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/mmio_fabric.sv
// MMIO fabric between the RV32 core and NUM_DEV peripherals: address decode,
// wait-state handshake with timeout, lane handling and a saturating error count.
module mmio_fabric
    import mmio_pkg::*;
#(
    parameter int NUM_DEV = 4,
    parameter int DATA_W  = 32,
    parameter int SEL_LSB = 8,
    parameter int SEL_W   = 4,
    parameter int OFS_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    mmio_cpu_if.slave  cpu,
    mmio_dev_if.master dev
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t               state_reg, state_next;
    logic                 we_reg;
    logic [2:0]           f3_reg;
    logic [1:0]           lo_reg;
    logic [OFS_W-3:0]     ofs_reg;
    logic [SEL_W-1:0]     idx_reg;
    logic [DATA_W-1:0]    wdata_reg;
    logic [7:0]           tmo_reg, tmo_next;
    logic                 done_reg, done_next;
    logic                 err_reg, err_next;
    logic [DATA_W-1:0]    rdata_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    logic                 latch_en;
    logic                 rdata_load;
    logic                 req_bad;
    logic [SEL_W-1:0]     cpu_idx;
    logic [NUM_DEV-1:0]   req_vec;
    logic                 sel_ready;
    logic [DATA_W-1:0]    sel_rdata;
    logic [DATA_W-1:0]    ld_data;
    logic [DATA_W-1:0]    st_data;
    logic [3:0]           st_be;
    logic                 unused_addr;

    // Upper address bits above the select field are not decoded.
    assign unused_addr = ^cpu.cpu_addr;

    assign cpu_idx = cpu.cpu_addr[SEL_LSB +: SEL_W];
    assign req_bad = (int'(cpu_idx) >= NUM_DEV) ||
                     access_illegal(cpu.cpu_we, cpu.cpu_funct3, cpu.cpu_addr[1:0]);

    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_dev
        assign req_vec[gi] = (state_reg == WAIT) && (idx_reg == SEL_W'(gi));
    end

    // Only the selected device can complete the access; other readies are masked.
    assign sel_ready = |(req_vec & dev.dev_ready);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (req_vec[i]) begin
                sel_rdata = sel_rdata | dev.dev_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    mmio_lane u_lane (
        .we        (we_reg),
        .funct3    (f3_reg),
        .addr_lo   (lo_reg),
        .wdata     (wdata_reg),
        .rdata     (sel_rdata),
        .be        (st_be),
        .wdata_rep (st_data),
        .rdata_ext (ld_data)
    );

    always_comb begin
        state_next = state_reg;
        tmo_next   = tmo_reg;
        latch_en   = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        rdata_load = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (cpu.cpu_req) begin
                    latch_en   = 1'b1;
                    tmo_next   = '0;
                    state_next = req_bad ? RESP : WAIT;
                    done_next  = req_bad;
                    err_next   = req_bad;
                end
            end
            WAIT: begin
                if (sel_ready) begin
                    state_next = RESP;
                    done_next  = 1'b1;
                    rdata_load = 1'b1;
                end else if (tmo_reg == TMO_LAST) begin
                    state_next = RESP;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                end else begin
                    tmo_next = tmo_reg + 8'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            we_reg      <= 1'b0;
            f3_reg      <= '0;
            lo_reg      <= '0;
            ofs_reg     <= '0;
            idx_reg     <= '0;
            wdata_reg   <= '0;
            tmo_reg     <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            rdata_reg   <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            tmo_reg   <= tmo_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            if (latch_en) begin
                we_reg    <= cpu.cpu_we;
                f3_reg    <= cpu.cpu_funct3;
                lo_reg    <= cpu.cpu_addr[1:0];
                ofs_reg   <= cpu.cpu_addr[OFS_W-1:2];
                idx_reg   <= cpu_idx;
                wdata_reg <= cpu.cpu_wdata;
            end
            // Failed accesses return zero so stale data never reaches the core.
            if (done_next) begin
                rdata_reg <= rdata_load ? ld_data : '0;
            end
            if (done_next && err_next && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign dev.dev_req   = req_vec;
    assign dev.dev_we    = (state_reg == WAIT) && we_reg;
    assign dev.dev_addr  = {ofs_reg, 2'b00};
    assign dev.dev_wdata = st_data;
    assign dev.dev_be    = (state_reg == WAIT) ? st_be : 4'b0000;

    assign cpu.cpu_stall = cpu.cpu_req && !done_reg;
    assign cpu.cpu_done  = done_reg;
    assign cpu.cpu_err   = err_reg;
    assign cpu.cpu_rdata = rdata_reg;
    assign cpu.err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_mmio_fabric.sv
// Scoreboard bench for mmio_fabric: directed accesses push expected responses,
// a negedge monitor checks device-side strobes and every cpu_done against them.
module tb_mmio_fabric;
    import mmio_pkg::*;

    localparam int NUM_DEV = 4;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_cpu_if cpu ();
    mmio_dev_if #(.NUM_DEV(NUM_DEV), .OFS_W(8)) dev ();

    mmio_fabric #(
        .NUM_DEV (NUM_DEV),
        .DATA_W  (32),
        .SEL_LSB (8),
        .SEL_W   (4),
        .OFS_W   (8),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cpu (cpu),
        .dev (dev)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        int          done_cyc;
        int          reqc;
        logic [3:0]  req;
        logic        we;
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_run = 0;
    int          req_seen = 0;
    int          txn = 0;
    int          rdy_at = 0;
    logic [7:0]  err_model = 8'd0;
    logic [3:0]  noise = 4'b0000;
    logic [31:0] dev_data [NUM_DEV];

    always @(posedge clk) cyc <= cyc + 1;

    // Device model: selected device raises ready in WAIT cycle rdy_at (0 = never).
    always @(negedge clk) req_run <= (dev.dev_req != '0) ? req_run + 1 : 0;
    assign dev.dev_ready = (((rdy_at != 0) && (req_run == rdy_at)) ? dev.dev_req : 4'b0000) | noise;
    assign dev.dev_rdata = {dev_data[3], dev_data[2], dev_data[1], dev_data[0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            exp_q.delete();
            req_seen = 0;
        end else begin
            if (dev.dev_req != '0) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_dev_req", 32'(dev.dev_req), 32'd0);
                end else begin
                    req_seen++;
                    chk("dev_req", 32'(dev.dev_req), 32'(exp_q[0].req));
                    chk("dev_we", 32'(dev.dev_we), 32'(exp_q[0].we));
                    chk("dev_addr", 32'(dev.dev_addr), 32'(exp_q[0].addr));
                    chk("dev_be", 32'(dev.dev_be), 32'(exp_q[0].be));
                    if (exp_q[0].we) chk("dev_wdata", dev.dev_wdata, exp_q[0].wdata);
                end
            end
            if (cpu.cpu_done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 32'(cpu.cpu_done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    txn++;
                    $display("txn %0d cyc=%0d err=%0b rdata=%h err_cnt=%0d",
                             txn, cyc, cpu.cpu_err, cpu.cpu_rdata, cpu.err_cnt);
                    chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    chk("cpu_err", 32'(cpu.cpu_err), 32'(e.err));
                    if (e.chk_rd) chk("cpu_rdata", cpu.cpu_rdata, e.rdata);
                    chk("req_cycles", 32'(req_seen), 32'(e.reqc));
                    chk("err_cnt", 32'(cpu.err_cnt), 32'(e.cnt));
                    req_seen = 0;
                end
            end
        end
    end

    task automatic access(
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] wd,
        input logic [2:0]  f3,
        input int          ready_at,
        input logic [31:0] exp_rd,
        input logic        exp_err,
        input int          exp_lat,
        input int          exp_reqc,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wd
    );
        exp_t e;
        int   n;
        if (exp_err && (err_model != 8'hFF)) err_model++;
        e.rdata    = exp_rd;
        e.err      = exp_err;
        e.chk_rd   = !we || exp_err;
        e.done_cyc = cyc + exp_lat;
        e.reqc     = exp_reqc;
        e.req      = 4'(1 << addr[9:8]);
        e.we       = we;
        e.addr     = {addr[7:2], 2'b00};
        e.be       = exp_be;
        e.wdata    = exp_wd;
        e.cnt      = err_model;
        exp_q.push_back(e);
        rdy_at         = ready_at;
        cpu.cpu_we     = we;
        cpu.cpu_addr   = addr;
        cpu.cpu_wdata  = wd;
        cpu.cpu_funct3 = f3;
        cpu.cpu_req    = 1'b1;
        @(negedge clk);
        n = 1;
        if (exp_lat > 1) chk("cpu_stall_busy", 32'(cpu.cpu_stall), 32'd1);
        while (!cpu.cpu_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!cpu.cpu_done) chk("done_wait_expired", 32'(cpu.cpu_done), 32'd1);
        else chk("cpu_stall_done", 32'(cpu.cpu_stall), 32'd0);
        cpu.cpu_req = 1'b0;
        rdy_at      = 0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        exp_t e;
        cpu.cpu_req    = 1'b0;
        cpu.cpu_we     = 1'b0;
        cpu.cpu_addr   = '0;
        cpu.cpu_wdata  = '0;
        cpu.cpu_funct3 = '0;
        for (int i = 0; i < NUM_DEV; i++) dev_data[i] = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_dev_req", 32'(dev.dev_req), 32'd0);
        chk("rst_cpu_done", 32'(cpu.cpu_done), 32'd0);
        chk("rst_cpu_err", 32'(cpu.cpu_err), 32'd0);
        chk("rst_cpu_rdata", cpu.cpu_rdata, 32'd0);
        chk("rst_err_cnt", 32'(cpu.err_cnt), 32'd0);
        chk("rst_dev_we", 32'(dev.dev_we), 32'd0);
        chk("rst_dev_be", 32'(dev.dev_be), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LW with 3 wait cycles; device 2 asserts a stray ready throughout.
        dev_data[1] = 32'hDEADBEEF;
        dev_data[2] = 32'h5555AAAA;
        noise = 4'b0100;
        access(1'b0, 32'h104, 32'h0, F3_W, 3, 32'hDEADBEEF, 1'b0, 4, 3, 4'hF, 32'h0);
        noise = 4'b0000;

        // Stores: lane enables and replication.
        access(1'b1, 32'h308, 32'h12345678, F3_W, 1, 32'h0, 1'b0, 2, 1, 4'b1111, 32'h12345678);
        access(1'b1, 32'h203, 32'h000000A5, F3_B, 2, 32'h0, 1'b0, 3, 2, 4'b1000, 32'hA5A5A5A5);
        access(1'b1, 32'h201, 32'h12345678, F3_B, 1, 32'h0, 1'b0, 2, 1, 4'b0010, 32'h78787878);
        access(1'b1, 32'h106, 32'h0000BEEF, F3_H, 1, 32'h0, 1'b0, 2, 1, 4'b1100, 32'hBEEFBEEF);
        access(1'b1, 32'h004, 32'hCAFE1234, F3_H, 1, 32'h0, 1'b0, 2, 1, 4'b0011, 32'h12341234);

        // Loads: extraction and extension.
        dev_data[2] = 32'h80000000;
        access(1'b0, 32'h203, 32'h0, F3_B,  1, 32'hFFFFFF80, 1'b0, 2, 1, 4'hF, 32'h0);
        access(1'b0, 32'h203, 32'h0, F3_BU, 1, 32'h00000080, 1'b0, 2, 1, 4'hF, 32'h0);
        dev_data[1] = 32'h80017F34;
        access(1'b0, 32'h102, 32'h0, F3_H,  1, 32'hFFFF8001, 1'b0, 2, 1, 4'hF, 32'h0);
        access(1'b0, 32'h102, 32'h0, F3_HU, 1, 32'h00008001, 1'b0, 2, 1, 4'hF, 32'h0);
        access(1'b0, 32'h100, 32'h0, F3_H,  1, 32'h00007F34, 1'b0, 2, 1, 4'hF, 32'h0);
        access(1'b0, 32'h101, 32'h0, F3_B,  2, 32'h0000007F, 1'b0, 3, 2, 4'hF, 32'h0);
        access(1'b0, 32'h102, 32'h0, F3_BU, 1, 32'h00000001, 1'b0, 2, 1, 4'hF, 32'h0);
        access(1'b0, 32'h103, 32'h0, F3_B,  1, 32'hFFFFFF80, 1'b0, 2, 1, 4'hF, 32'h0);

        // Decode and alignment errors: done in cycle 1, no device request.
        access(1'b0, 32'h101, 32'h0, F3_H,   1, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
        access(1'b0, 32'h500, 32'h0, F3_W,   1, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
        access(1'b0, 32'hF00, 32'h0, F3_W,   1, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
        access(1'b0, 32'h102, 32'h0, F3_W,   1, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
        access(1'b0, 32'h100, 32'h0, 3'b011, 1, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
        access(1'b0, 32'h100, 32'h0, 3'b110, 1, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
        access(1'b1, 32'h100, 32'h0, 3'b100, 1, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
        access(1'b1, 32'h103, 32'h0, F3_H,   1, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);

        // Timeout with stray readies on other devices, then ready on the last cycle.
        dev_data[0] = 32'h11112222;
        noise = 4'b1110;
        access(1'b0, 32'h000, 32'h0, F3_W, 0, 32'h0, 1'b1, TIMEOUT + 1, TIMEOUT, 4'hF, 32'h0);
        noise = 4'b0000;
        access(1'b0, 32'h008, 32'h0, F3_W, TIMEOUT, 32'h11112222, 1'b0, TIMEOUT + 1, TIMEOUT, 4'hF, 32'h0);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) access(1'b0, 32'h101, 32'h0, F3_H, 1, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
            else            access(1'b0, 32'h400, 32'h0, F3_W, 1, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
        end
        chk("err_cnt_saturated", 32'(cpu.err_cnt), 32'd255);

        // Reset in the second WAIT cycle aborts without a completion.
        e.req  = 4'b0010;
        e.we   = 1'b0;
        e.addr = 8'h00;
        e.be   = 4'hF;
        exp_q.push_back(e);
        rdy_at         = 0;
        cpu.cpu_we     = 1'b0;
        cpu.cpu_addr   = 32'h100;
        cpu.cpu_funct3 = F3_W;
        cpu.cpu_req    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_req_before_rst", 32'(dev.dev_req), 32'h2);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_dev_req", 32'(dev.dev_req), 32'd0);
        chk("abort_cpu_done", 32'(cpu.cpu_done), 32'd0);
        chk("abort_err_cnt", 32'(cpu.err_cnt), 32'd0);
        cpu.cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        err_model = 8'd0;
        repeat (6) @(negedge clk);

        dev_data[1] = 32'hA5A55A5A;
        access(1'b0, 32'h100, 32'h0, F3_W, 1, 32'hA5A55A5A, 1'b0, 2, 1, 4'hF, 32'h0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
